parking_lot_tracker: RTL and testbench
======================================

// Module: parking_lot_tracker
// PURPOSE
//  Parametrised occupancy and gate controller for an N-spot lot. Replaces the fixed 3-spot logic.
//  Synchronises the raw entrance/exit presence sensors and drives the gate-open outputs.
//  Keeps a saturating car count and a per-hour log of entries in an internal array.
//  Detects the rush window (first hour full -> first later hour empty) and sits between GPIO and the HEX display datapath.
// PARAMETERS
//  NUM_SPOTS   3   lot capacity; count range 0..NUM_SPOTS
//  NUM_HOURS   8   hours in a working day; hour range 0..NUM_HOURS-1
//  LOG_W       4   width of each per-hour entry counter (saturates at 2**LOG_W-1)
// PORTS
//  clock          in   1                     system clock (50 MHz)
//  reset          in   1                     asynchronous, active-low; clears all state
//  enter_raw      in   1                     unsynchronised entrance presence sensor, high = car present
//  exit_raw       in   1                     unsynchronised exit presence sensor, high = car present
//  hour_inc       in   1                     single-cycle pulse: advance to next hour (already synced)
//  rd_hour        in   $clog2(NUM_HOURS)     history read address
//  count          out  $clog2(NUM_SPOTS+1)   cars currently inside
//  hour           out  $clog2(NUM_HOURS)     current hour index
//  full / empty   out  1                     count==NUM_SPOTS / count==0
//  open_entrance  out  1                     entrance gate open command
//  open_exit      out  1                     exit gate open command
//  rush_start     out  $clog2(NUM_HOURS)     hour the lot first became full
//  rush_end       out  $clog2(NUM_HOURS)     first later hour the lot became empty again
//  rush_valid     out  2                     bit0: rush_start valid; bit1: rush_end valid
//  day_done       out  1                     set after the last hour elapses; sticky
//  rd_entries     out  LOG_W                 entries logged for rd_hour; registered, 1-cycle read latency
// BEHAVIOUR
//  Reset: count=0, hour=0, gates closed, rush_valid=0, rush_start=rush_end=0, day_done=0, rd_entries=0, all log entries=0.
//  Sensors: 2-flop synchroniser each, then rise/fall edge detect on the synced level; 2-cycle latency from pin to edge.
//  Entrance FSM: E_IDLE -> E_OPEN on enter rise if !full; E_IDLE -> E_BLOCK on enter rise if full.
//  Entrance FSM: E_OPEN -> E_IDLE on enter fall: count+1, log[hour]+1 (saturating) in the same cycle.
//  Entrance FSM: E_BLOCK -> E_IDLE on enter fall, no count change. open_entrance = (state==E_OPEN).
//  Exit FSM: X_IDLE -> X_OPEN on exit rise if !empty, else ignored. X_OPEN -> X_IDLE on exit fall: count-1.
//  Exit FSM: open_exit = (state==X_OPEN).
//  Simultaneous entry-complete and exit-complete in one cycle: count unchanged, log[hour] still incremented.
//  count never exceeds NUM_SPOTS nor goes below 0. An entry completing at full is impossible by construction.
//  Rush start: first cycle count becomes NUM_SPOTS while rush_valid[0]==0 -> rush_start=hour, set rush_valid[0].
//  Rush end: first cycle count becomes 0 while rush_valid==2'b01 and hour>rush_start -> rush_end=hour, set rush_valid[1].
//  Rush: both captures are one-shot per day.
//  Hours: hour_inc with hour<NUM_HOURS-1 -> hour+1. hour_inc at NUM_HOURS-1 -> hour holds, day_done=1.
//  After day_done: hour_inc is ignored and logging stops. Gates and count still operate.
//  Log: NUM_HOURS x LOG_W array. rd_entries <= log[rd_hour] every clock. A same-cycle write is not forwarded (old value).
//  Reset mid-operation: asserting reset while a gate is open closes it immediately (async). Car in transit is not counted.
// TESTING
//  1. Reset, enter_raw pulse 3 cycles high (NUM_SPOTS=3) -> open_entrance high ~2 cycles after rise; on fall count=1, log[0]=1.
//  2. Three entries, then a 4th enter pulse -> full=1, 4th gives open_entrance=0, count stays 3. rush_start=0, rush_valid=01.
//  3. hour_inc x2, then three exits -> count=0, empty=1, rush_end=2, rush_valid=11. Exit pulse at empty -> open_exit stays 0.
//  4. count=1; enter and exit falls aligned to the same cycle -> count stays 1, log[hour]+1.
//  5. 8 hour_inc pulses (NUM_HOURS=8) -> hour=7, day_done=1. 9th pulse -> no change. Entries no longer logged.
//  6. Drop reset low while E_OPEN -> open_entrance=0 asynchronously, count=0, all rd_entries read 0 after release.

Source files
------------

// File: rtl/parking_lot_tracker_if.sv
// Signal bundle between the GPIO/sensor side and the parking lot tracker.
// master drives sensors and queries; slave (the tracker) returns status and history.
`timescale 1ns / 1ps

interface parking_lot_tracker_if #(
   parameter int unsigned NUM_SPOTS = 3,
   parameter int unsigned NUM_HOURS = 8,
   parameter int unsigned LOG_W     = 4
);
   localparam int unsigned CW = $clog2(NUM_SPOTS + 1);
   localparam int unsigned HW = $clog2(NUM_HOURS);

   logic          enter_raw;
   logic          exit_raw;
   logic          hour_inc;
   logic [HW-1:0] rd_hour;

   logic [CW-1:0]    count;
   logic [HW-1:0]    hour;
   logic             full;
   logic             empty;
   logic             open_entrance;
   logic             open_exit;
   logic [HW-1:0]    rush_start;
   logic [HW-1:0]    rush_end;
   logic [1:0]       rush_valid;
   logic             day_done;
   logic [LOG_W-1:0] rd_entries;

   modport master (
      output enter_raw, exit_raw, hour_inc, rd_hour,
      input  count, hour, full, empty, open_entrance, open_exit,
      input  rush_start, rush_end, rush_valid, day_done, rd_entries
   );

   modport slave (
      input  enter_raw, exit_raw, hour_inc, rd_hour,
      output count, hour, full, empty, open_entrance, open_exit,
      output rush_start, rush_end, rush_valid, day_done, rd_entries
   );
endinterface

// File: rtl/parking_lot_tracker.sv
// Occupancy and gate controller for an N-spot lot: sensor sync, gate FSMs, saturating count,
// per-hour entry log and rush-window capture.
`timescale 1ns / 1ps

module parking_lot_tracker #(
   parameter int unsigned NUM_SPOTS = 3,
   parameter int unsigned NUM_HOURS = 8,
   parameter int unsigned LOG_W     = 4
) (
   input logic                   clock,
   input logic                   reset,
   parking_lot_tracker_if.slave  bus
);
   localparam int unsigned CW = $clog2(NUM_SPOTS + 1);
   localparam int unsigned HW = $clog2(NUM_HOURS);

   localparam logic [CW-1:0]    FULL_CNT  = CW'(NUM_SPOTS);
   localparam logic [CW-1:0]    CNT_STEP  = 1;
   localparam logic [HW-1:0]    LAST_HOUR = HW'(NUM_HOURS - 1);
   localparam logic [HW-1:0]    HOUR_STEP = 1;
   localparam logic [LOG_W-1:0] LOG_MAX   = '1;
   localparam logic [LOG_W-1:0] LOG_STEP  = 1;

   localparam logic [1:0] E_IDLE  = 2'd0;
   localparam logic [1:0] E_OPEN  = 2'd1;
   localparam logic [1:0] E_BLOCK = 2'd2;
   localparam logic       X_IDLE  = 1'b0;
   localparam logic       X_OPEN  = 1'b1;

   logic enter_meta_q, enter_sync_q, enter_prev_q;
   logic exit_meta_q, exit_sync_q, exit_prev_q;
   logic enter_rise, enter_fall, exit_rise, exit_fall;

   logic [1:0]       ent_state_q, ent_state_d;
   logic             ex_state_q, ex_state_d;
   logic             entry_done, exit_done;
   logic [CW-1:0]    count_q, count_d;
   logic             lot_full, lot_empty;
   logic [HW-1:0]    hour_q, hour_d;
   logic             day_done_q, day_done_d;
   logic [HW-1:0]    rush_start_q, rush_start_d;
   logic [HW-1:0]    rush_end_q, rush_end_d;
   logic [1:0]       rush_valid_q, rush_valid_d;
   logic             log_we;
   logic [LOG_W-1:0] log_q [NUM_HOURS];
   logic [LOG_W-1:0] rd_entries_q;

   assign enter_rise = enter_sync_q & ~enter_prev_q;
   assign enter_fall = ~enter_sync_q & enter_prev_q;
   assign exit_rise  = exit_sync_q & ~exit_prev_q;
   assign exit_fall  = ~exit_sync_q & exit_prev_q;

   assign lot_full  = (count_q == FULL_CNT);
   assign lot_empty = (count_q == '0);

   always_comb begin
      ent_state_d = ent_state_q;
      entry_done  = 1'b0;
      case (ent_state_q)
         E_IDLE:  if (enter_rise) ent_state_d = lot_full ? E_BLOCK : E_OPEN;
         E_OPEN:  if (enter_fall) begin
            ent_state_d = E_IDLE;
            entry_done  = 1'b1;
         end
         E_BLOCK: if (enter_fall) ent_state_d = E_IDLE;
         default: ent_state_d = E_IDLE;
      endcase
   end

   always_comb begin
      ex_state_d = ex_state_q;
      exit_done  = 1'b0;
      case (ex_state_q)
         X_IDLE: if (exit_rise && !lot_empty) ex_state_d = X_OPEN;
         X_OPEN: if (exit_fall) begin
            ex_state_d = X_IDLE;
            exit_done  = 1'b1;
         end
         default: ex_state_d = X_IDLE;
      endcase
   end

   // A car leaving while another arrives cancels out; bounds guard the count regardless.
   always_comb begin
      count_d = count_q;
      if (entry_done && !exit_done && !lot_full) begin
         count_d = count_q + CNT_STEP;
      end else if (exit_done && !entry_done && !lot_empty) begin
         count_d = count_q - CNT_STEP;
      end
   end

   always_comb begin
      rush_start_d = rush_start_q;
      rush_end_d   = rush_end_q;
      rush_valid_d = rush_valid_q;
      if (count_d == FULL_CNT && !lot_full && !rush_valid_q[0]) begin
         rush_start_d    = hour_q;
         rush_valid_d[0] = 1'b1;
      end
      if (count_d == '0 && !lot_empty && rush_valid_q == 2'b01 && hour_q > rush_start_q) begin
         rush_end_d      = hour_q;
         rush_valid_d[1] = 1'b1;
      end
   end

   always_comb begin
      hour_d     = hour_q;
      day_done_d = day_done_q;
      if (bus.hour_inc && !day_done_q) begin
         if (hour_q == LAST_HOUR) day_done_d = 1'b1;
         else                     hour_d     = hour_q + HOUR_STEP;
      end
   end

   assign log_we = entry_done && !day_done_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         enter_meta_q <= 1'b0;
         enter_sync_q <= 1'b0;
         enter_prev_q <= 1'b0;
         exit_meta_q  <= 1'b0;
         exit_sync_q  <= 1'b0;
         exit_prev_q  <= 1'b0;
         ent_state_q  <= E_IDLE;
         ex_state_q   <= X_IDLE;
         count_q      <= '0;
         hour_q       <= '0;
         day_done_q   <= 1'b0;
         rush_start_q <= '0;
         rush_end_q   <= '0;
         rush_valid_q <= 2'b00;
      end else begin
         enter_meta_q <= bus.enter_raw;
         enter_sync_q <= enter_meta_q;
         enter_prev_q <= enter_sync_q;
         exit_meta_q  <= bus.exit_raw;
         exit_sync_q  <= exit_meta_q;
         exit_prev_q  <= exit_sync_q;
         ent_state_q  <= ent_state_d;
         ex_state_q   <= ex_state_d;
         count_q      <= count_d;
         hour_q       <= hour_d;
         day_done_q   <= day_done_d;
         rush_start_q <= rush_start_d;
         rush_end_q   <= rush_end_d;
         rush_valid_q <= rush_valid_d;
      end
   end

   // Read port sees the pre-write value when it hits the hour being logged.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_HOURS; i++) log_q[i] <= '0;
         rd_entries_q <= '0;
      end else begin
         if (log_we && log_q[hour_q] != LOG_MAX) log_q[hour_q] <= log_q[hour_q] + LOG_STEP;
         rd_entries_q <= (32'(bus.rd_hour) < NUM_HOURS) ? log_q[bus.rd_hour] : '0;
      end
   end

   assign bus.count         = count_q;
   assign bus.hour          = hour_q;
   assign bus.full          = lot_full;
   assign bus.empty         = lot_empty;
   assign bus.open_entrance = (ent_state_q == E_OPEN);
   assign bus.open_exit     = (ex_state_q == X_OPEN);
   assign bus.rush_start    = rush_start_q;
   assign bus.rush_end      = rush_end_q;
   assign bus.rush_valid    = rush_valid_q;
   assign bus.day_done      = day_done_q;
   assign bus.rd_entries    = rd_entries_q;
endmodule

// File: tb/tb_parking_lot_tracker.sv
// Scoreboard bench: drivers push expected events from a transaction-level lot model,
// an independent negedge monitor pops and compares whenever the tracker shows a response.
`timescale 1ns / 1ps

module tb_parking_lot_tracker;
   localparam int unsigned N       = 3;
   localparam int unsigned NH      = 8;
   localparam int unsigned LW      = 4;
   localparam int unsigned CW      = $clog2(N + 1);
   localparam int unsigned HW      = $clog2(NH);
   localparam int          LOG_MAX = (1 << LW) - 1;

   typedef struct packed {
      logic [CW-1:0] count;
      logic [HW-1:0] hour;
      logic          full;
      logic          empty;
      logic [HW-1:0] rs;
      logic [HW-1:0] re;
      logic [1:0]    rv;
      logic          dd;
      logic          oe;
      logic          ox;
   } snap_t;

   logic clock = 1'b0;
   logic reset = 1'b0;

   parking_lot_tracker_if #(.NUM_SPOTS(N), .NUM_HOURS(NH), .LOG_W(LW)) bus ();

   parking_lot_tracker #(.NUM_SPOTS(N), .NUM_HOURS(NH), .LOG_W(LW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #10 clock = ~clock;

   int errors = 0;
   int checks = 0;

   int    ent_q [$];
   int    ex_q  [$];
   int    cnt_q [$];
   int    rd_q  [$];
   snap_t snap_q[$];

   // Reference lot: plain counters, one step per car transaction.
   int m_count, m_hour, m_rs, m_re;
   bit m_dd;
   bit [1:0] m_rv;
   int m_log [NH];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic model_reset();
      m_count = 0; m_hour = 0; m_rs = 0; m_re = 0; m_dd = 0; m_rv = 2'b00;
      for (int h = 0; h < NH; h++) m_log[h] = 0;
   endtask

   task automatic model_count(input int nc);
      int old;
      old = m_count;
      m_count = nc;
      if (nc != old) cnt_q.push_back(nc);
      if (nc == N && old != N && !m_rv[0]) begin
         m_rs = m_hour;
         m_rv[0] = 1'b1;
      end
      if (nc == 0 && old != 0 && m_rv == 2'b01 && m_hour > m_rs) begin
         m_re = m_hour;
         m_rv[1] = 1'b1;
      end
   endtask

   task automatic model_log_entry();
      if (!m_dd && m_log[m_hour] < LOG_MAX) m_log[m_hour]++;
   endtask

   function automatic snap_t model_snap();
      snap_t s;
      s.count = CW'(m_count);
      s.hour  = HW'(m_hour);
      s.full  = (m_count == N);
      s.empty = (m_count == 0);
      s.rs    = HW'(m_rs);
      s.re    = HW'(m_re);
      s.rv    = m_rv;
      s.dd    = m_dd;
      s.oe    = 1'b0;
      s.ox    = 1'b0;
      return s;
   endfunction

   task automatic expect_snapshot();
      snap_q.push_back(model_snap());
      tick(1);
   endtask

   task automatic car_enter(input int hold);
      if (m_count < N) begin
         ent_q.push_back(m_count);
         model_log_entry();
         model_count(m_count + 1);
      end
      bus.enter_raw = 1'b1;
      tick(hold);
      bus.enter_raw = 1'b0;
      tick(5);
   endtask

   task automatic car_exit(input int hold);
      if (m_count > 0) begin
         ex_q.push_back(m_count);
         model_count(m_count - 1);
      end
      bus.exit_raw = 1'b1;
      tick(hold);
      bus.exit_raw = 1'b0;
      tick(5);
   endtask

   // Both sensors rise and fall in the same cycle so both gate completions coincide.
   task automatic car_both(input int hold);
      bit eo, xo;
      eo = (m_count < N);
      xo = (m_count > 0);
      if (eo) ent_q.push_back(m_count);
      if (xo) ex_q.push_back(m_count);
      if (eo) model_log_entry();
      model_count(m_count + int'(eo) - int'(xo));
      bus.enter_raw = 1'b1;
      bus.exit_raw  = 1'b1;
      tick(hold);
      bus.enter_raw = 1'b0;
      bus.exit_raw  = 1'b0;
      tick(5);
   endtask

   task automatic hour_tick();
      if (!m_dd) begin
         if (m_hour < NH - 1) m_hour++;
         else                 m_dd = 1'b1;
      end
      bus.hour_inc = 1'b1;
      tick(1);
      bus.hour_inc = 1'b0;
      tick(1);
   endtask

   task automatic read_all();
      for (int h = 0; h < NH; h++) begin
         bus.rd_hour = HW'(h);
         rd_q.push_back(m_log[h]);
         tick(1);
      end
      tick(2);
   endtask

   task automatic random_ops(input int n);
      int r, hold;
      for (int i = 0; i < n; i++) begin
         r    = int'($urandom_range(0, 99));
         hold = int'($urandom_range(2, 5));
         if (r < 45)      car_enter(hold);
         else if (r < 80) car_exit(hold);
         else if (r < 90) car_both(hold);
         else             hour_tick();
         if (i % 5 == 4) expect_snapshot();
      end
   endtask

   // Monitor: compares whenever the tracker presents a response.
   logic [CW-1:0] prev_cnt = '0;
   logic          prev_oe = 1'b0;
   logic          prev_ox = 1'b0;
   bit            rd_pend = 1'b0;
   int            rd_hold = 0;

   initial begin
      snap_t act;
      forever begin
         @(negedge clock);
         if (rd_pend) begin
            check("rd_entries", 64'(bus.rd_entries), 64'(rd_hold));
            rd_pend = 1'b0;
         end
         if (rd_q.size() > 0) begin
            rd_hold = rd_q.pop_front();
            rd_pend = 1'b1;
         end
         if (snap_q.size() > 0) begin
            act = '{count: bus.count, hour: bus.hour, full: bus.full, empty: bus.empty,
                    rs: bus.rush_start, re: bus.rush_end, rv: bus.rush_valid,
                    dd: bus.day_done, oe: bus.open_entrance, ox: bus.open_exit};
            check("status", 64'(act), 64'(snap_q.pop_front()));
         end
         if (bus.open_entrance && !prev_oe) begin
            if (ent_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL entrance_open: gate opened at count=%0d, expected closed", bus.count);
            end else begin
               check("entrance_open_count", 64'(bus.count), 64'(ent_q.pop_front()));
            end
         end
         if (bus.open_exit && !prev_ox) begin
            if (ex_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL exit_open: gate opened at count=%0d, expected closed", bus.count);
            end else begin
               check("exit_open_count", 64'(bus.count), 64'(ex_q.pop_front()));
            end
         end
         if (bus.count != prev_cnt) begin
            if (cnt_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL count_change: count=%0d, expected %0d", bus.count, prev_cnt);
            end else begin
               check("count_change", 64'(bus.count), 64'(cnt_q.pop_front()));
            end
         end
         prev_cnt = bus.count;
         prev_oe  = bus.open_entrance;
         prev_ox  = bus.open_exit;
      end
   end

   initial begin
      bus.enter_raw = 1'b0;
      bus.exit_raw  = 1'b0;
      bus.hour_inc  = 1'b0;
      bus.rd_hour   = '0;
      model_reset();
      tick(3);
      reset = 1'b1;
      tick(1);
      expect_snapshot();
      read_all();

      // First entry, fill to capacity, then a blocked arrival.
      car_enter(3);
      expect_snapshot();
      car_enter(3);
      car_enter(3);
      expect_snapshot();
      car_enter(3);
      expect_snapshot();

      // Empty out two hours later to close the rush window, then a spurious exit.
      hour_tick();
      hour_tick();
      car_exit(3);
      car_exit(3);
      car_exit(3);
      expect_snapshot();
      car_exit(3);
      expect_snapshot();

      // Coincident entry and exit with one car inside.
      car_enter(2);
      car_both(3);
      expect_snapshot();
      read_all();

      random_ops(30);
      expect_snapshot();
      read_all();

      // Run the day out, then one extra tick and an entry that must not be logged.
      repeat (NH) hour_tick();
      expect_snapshot();
      hour_tick();
      car_enter(3);
      expect_snapshot();
      read_all();

      // Asynchronous reset while the entrance gate is open.
      if (m_count == N) car_exit(3);
      if (m_count < N) ent_q.push_back(m_count);
      bus.enter_raw = 1'b1;
      tick(4);
      #2;
      if (m_count != 0) cnt_q.push_back(0);
      model_reset();
      snap_q.push_back(model_snap());
      reset = 1'b0;
      tick(2);
      bus.enter_raw = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(2);
      read_all();
      expect_snapshot();

      random_ops(30);
      expect_snapshot();
      read_all();

      tick(6);
      check("pending_entrance_events", 64'(ent_q.size()), 64'(0));
      check("pending_exit_events", 64'(ex_q.size()), 64'(0));
      check("pending_count_events", 64'(cnt_q.size()), 64'(0));
      check("pending_status_checks", 64'(snap_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
